reg8_wr_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the 8-entry register file among NREQ requesters.

---
 rtl/reg8_wr_arbiter_pkg.sv | 18 +
 rtl/reg8_wr_arbiter_rr_pick.sv | 30 +++
 rtl/reg8_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_reg8_wr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg8_wr_arbiter_pkg.sv
// Shared register-file constants and arbiter FSM encodings for reg8_wr_arbiter.
package reg8_wr_arbiter_pkg;

  localparam int unsigned NREG   = 8;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned SRC_W  = 3;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Only registers 0..NREG-1 exist; wider addresses are flagged, not written.
  function automatic logic addr_legal(input logic [REG_AW-1:0] addr);
    return addr < REG_AW'(NREG);
  endfunction

endpackage

// File: rtl/reg8_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or above ptr, wrapping, wins.
module reg8_wr_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = PW'((32'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/reg8_wr_arbiter.sv
// Round-robin arbiter for the 8-entry register file write port.
// Define REG8_WR_ARB_LOCK_EN to enable owner burst locking (ARB/LOCK FSM).
module reg8_wr_arbiter
  import reg8_wr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0]     req_data,
  input  logic [NREQ-1:0]        req_lock,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   stall,
  output logic                   wr_en,
  output logic [REG_AW-1:0]      wr_sel,
  output logic [DW-1:0]          wr_data,
  output logic [SRC_W-1:0]       wr_src,
  output logic                   addr_err
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]     ptr;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              accept;
  logic              legal;
  logic [REG_AW-1:0] sel_addr;
  logic [DW-1:0]     sel_data;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef REG8_WR_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  arb_state_t    state;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;
  logic          sel_lock;

  // While locked, only the owner is eligible.
  always_comb begin
    elig = req_valid;
    if (state == ST_LOCK) begin
      elig = req_valid & (NREQ'(1) << owner);
    end
  end
`else
  localparam int unsigned UNUSED_MAX_LOCK = MAX_LOCK;
  logic unused_lock;

  assign unused_lock = ^req_lock;
  assign elig        = req_valid;
`endif

  reg8_wr_arbiter_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign req_ready = (rst || stall) ? '0 : gnt;
  assign accept    = pick_any && !stall && !rst;

  // Payload of the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
`ifdef REG8_WR_ARB_LOCK_EN
    sel_lock = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*REG_AW +: REG_AW];
        sel_data = req_data[i*DW +: DW];
`ifdef REG8_WR_ARB_LOCK_EN
        sel_lock = req_lock[i];
`endif
      end
    end
  end

  assign legal = addr_legal(sel_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en    <= 1'b0;
      wr_sel   <= '0;
      wr_data  <= '0;
      wr_src   <= '0;
      addr_err <= 1'b0;
      ptr      <= '0;
`ifdef REG8_WR_ARB_LOCK_EN
      state    <= ST_ARB;
      owner    <= '0;
      cnt      <= '0;
`endif
    end else begin
      wr_en    <= accept && legal;
      addr_err <= accept && !legal;
      if (accept && legal) begin
        wr_sel  <= sel_addr;
        wr_data <= sel_data;
        wr_src  <= SRC_W'(pick_idx);
      end
`ifdef REG8_WR_ARB_LOCK_EN
      case (state)
        ST_ARB: begin
          if (accept) begin
            ptr <= inc_ptr(pick_idx);
            if (sel_lock && (MAX_LOCK > 1)) begin
              state <= ST_LOCK;
              owner <= pick_idx;
              cnt   <= CW'(1);
            end
          end
        end
        ST_LOCK: begin
          // Stall freezes the burst; otherwise a valid owner is always accepted.
          if (!stall) begin
            if (!req_valid[owner]) begin
              state <= ST_ARB;
              ptr   <= inc_ptr(owner);
            end else if (accept) begin
              cnt <= cnt + 1'b1;
              if (!sel_lock || ((cnt + 1'b1) == CW'(MAX_LOCK))) begin
                state <= ST_ARB;
                ptr   <= inc_ptr(owner);
              end
            end
          end
        end
        default: state <= ST_ARB;
      endcase
`else
      if (accept) begin
        ptr <= inc_ptr(pick_idx);
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg8_wr_arbiter.sv
// Directed self-checking bench for reg8_wr_arbiter (NREQ=4, DW=8, MAX_LOCK=4).
module tb_reg8_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [3:0]  req_ready;
  logic        stall;
  logic        wr_en;
  logic [3:0]  wr_sel;
  logic [7:0]  wr_data;
  logic [2:0]  wr_src;
  logic        addr_err;

  int tests = 0;
  int fails = 0;

  reg8_wr_arbiter #(
    .NREQ     (4),
    .DW       (8),
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .stall     (stall),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .wr_src    (wr_src),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    stall     = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [7:0] d, input logic l);
    req_valid[i]       = 1'b1;
    req_addr[i*4 +: 4] = a;
    req_data[i*8 +: 8] = d;
    req_lock[i]        = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 8'(8'h80 + i), 1'b0);
    step();
    step();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tests++; if (wr_en !== 1'b0)      begin fails++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    tests++; if (wr_sel !== 4'h0)     begin fails++; $display("FAIL reset_wr_sel got=%h exp=0", wr_sel); end
    tests++; if (wr_data !== 8'h00)   begin fails++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    tests++; if (wr_src !== 3'd0)     begin fails++; $display("FAIL reset_wr_src got=%0d exp=0", wr_src); end
    tests++; if (addr_err !== 1'b0)   begin fails++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 8'(8'h10 + i), 1'b0);
    #1;
    tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL rr_first_wr_en got=%b exp=0", wr_en); end
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      tests++; if (req_ready !== 4'(1 << g)) begin fails++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << g)); end
      step();
      tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL rr_wr_en k=%0d got=%b exp=1", k, wr_en); end
      tests++; if (wr_sel !== 4'(g + 1)) begin fails++; $display("FAIL rr_wr_sel k=%0d got=%h exp=%h", k, wr_sel, 4'(g + 1)); end
      tests++; if (wr_data !== 8'(8'h10 + g)) begin fails++; $display("FAIL rr_wr_data k=%0d got=%h exp=%h", k, wr_data, 8'(8'h10 + g)); end
      tests++; if (wr_src !== 3'(g)) begin fails++; $display("FAIL rr_wr_src k=%0d got=%0d exp=%0d", k, wr_src, g); end
      #1;
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 4'd5, 8'hA5, 1'b0);
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    step();
    tests++; if (wr_en !== 1'b1)    begin fails++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
    tests++; if (wr_sel !== 4'd5)   begin fails++; $display("FAIL single_wr_sel got=%h exp=5", wr_sel); end
    tests++; if (wr_data !== 8'hA5) begin fails++; $display("FAIL single_wr_data got=%h exp=a5", wr_data); end
    tests++; if (wr_src !== 3'd1)   begin fails++; $display("FAIL single_wr_src got=%0d exp=1", wr_src); end
    for (int i = 0; i < 4; i++) set_req(i, 4'd7, 8'(8'h20 + i), 1'b0);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_next_ptr got=%b exp=0100", req_ready); end
    step();
    tests++; if (wr_src !== 3'd2) begin fails++; $display("FAIL single_next_src got=%0d exp=2", wr_src); end
  endtask

  task automatic test_addr_err();
    do_reset();
    set_req(2, 4'd9, 8'h33, 1'b0);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL err_ready got=%b exp=0100", req_ready); end
    step();
    tests++; if (wr_en !== 1'b0)    begin fails++; $display("FAIL err_wr_en got=%b exp=0", wr_en); end
    tests++; if (addr_err !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", addr_err); end
    clear_reqs();
    for (int i = 0; i < 4; i++) set_req(i, 4'd4, 8'(8'h60 + i), 1'b0);
    #1;
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL err_next_ptr got=%b exp=1000", req_ready); end
    step();
    tests++; if (addr_err !== 1'b0) begin fails++; $display("FAIL err_pulse_end got=%b exp=0", addr_err); end
    tests++; if (wr_en !== 1'b1)    begin fails++; $display("FAIL err_next_wr_en got=%b exp=1", wr_en); end
    tests++; if (wr_src !== 3'd3)   begin fails++; $display("FAIL err_next_src got=%0d exp=3", wr_src); end
  endtask

  task automatic test_stall();
    do_reset();
    set_req(0, 4'd1, 8'h01, 1'b0);
    step();
    set_req(1, 4'd2, 8'h02, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL stall_ready k=%0d got=%b exp=0000", k, req_ready); end
      step();
      tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL stall_wr_en k=%0d got=%b exp=0", k, wr_en); end
    end
    stall = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stall_resume got=%b exp=0010", req_ready); end
    step();
    tests++; if (wr_src !== 3'd1)   begin fails++; $display("FAIL stall_resume_src got=%0d exp=1", wr_src); end
    tests++; if (wr_data !== 8'h02) begin fails++; $display("FAIL stall_resume_data got=%h exp=02", wr_data); end
    req_valid[1] = 1'b0;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL stall_then_req0 got=%b exp=0001", req_ready); end
  endtask

  task automatic test_lock();
    int exp_seq [5];
`ifdef REG8_WR_ARB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 1, 0};
`endif
    do_reset();
    set_req(0, 4'd2, 8'h40, 1'b1);
    set_req(1, 4'd3, 8'h50, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (req_ready !== 4'(1 << exp_seq[k])) begin fails++; $display("FAIL lock_ready k=%0d got=%b exp=%b", k, req_ready, 4'(1 << exp_seq[k])); end
      step();
      tests++; if (wr_src !== 3'(exp_seq[k])) begin fails++; $display("FAIL lock_src k=%0d got=%0d exp=%0d", k, wr_src, exp_seq[k]); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_req(0, 4'd6, 8'hC0, 1'b0);
    set_req(1, 4'd6, 8'hC1, 1'b0);
    step();
    tests++; if (wr_data !== 8'hC0 || wr_sel !== 4'd6) begin fails++; $display("FAIL b2b_first got=%h/%h exp=6/c0", wr_sel, wr_data); end
    req_valid[0] = 1'b0;
    step();
    tests++; if (wr_data !== 8'hC1 || wr_sel !== 4'd6) begin fails++; $display("FAIL b2b_last got=%h/%h exp=6/c1", wr_sel, wr_data); end
    req_valid[1] = 1'b0;
    step();
    tests++; if (wr_en !== 1'b0 || wr_data !== 8'hC1) begin fails++; $display("FAIL b2b_hold got=%b/%h exp=0/c1", wr_en, wr_data); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(3, 4'd7, 8'h77, 1'b0);
    step();
    tests++; if (wr_en !== 1'b1) begin fails++; $display("FAIL mid_pre_wr_en got=%b exp=1", wr_en); end
    rst = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    step();
    tests++; if (wr_en !== 1'b0 || wr_sel !== 4'd0) begin fails++; $display("FAIL mid_discard got=%b/%h exp=0/0", wr_en, wr_sel); end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_addr_err();
    test_stall();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
